// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back self-test initiator for a single-port synchronous RAM.
// Writes pat(a) = seed ^ a over the whole address space, reads it back through a
// 1-cycle compare pipe, and reports pass / error count / first failing location.
// Optional macro BIST_INVERT_PASS_EN adds a second write/read pass using ~pat(a).
module ram_bist_ctrl #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [data_width-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [addr_width+1:0]   err_count,
    output logic [addr_width-1:0]   fail_addr,
    output logic [data_width-1:0]   fail_data,
    output logic                    ram_we,
    output logic [addr_width-1:0]   ram_addr,
    output logic [data_width-1:0]   ram_wdata,
    input  logic [data_width-1:0]   ram_rdata
);

    localparam int unsigned CW = addr_width + 2;
    localparam logic [addr_width-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
`ifdef BIST_INVERT_PASS_EN
        ,
        S_WRITE_INV,
        S_READ_INV,
        S_DRAIN_INV
`endif
    } state_t;

    // Address-derived pattern, optionally inverted.
    function automatic logic [data_width-1:0] pat(input logic [data_width-1:0] s,
                                                  input logic [addr_width-1:0] a,
                                                  input logic inv);
        pat = (s ^ data_width'(a)) ^ {data_width{inv}};
    endfunction

    state_t                  state, state_d;
    logic [addr_width-1:0]   a, a_d;
    logic [data_width-1:0]   seed_q, seed_d;
    logic                    rd_pend, rd_pend_d;
    logic [addr_width-1:0]   rd_addr, rd_addr_d;
    logic                    rd_inv;
`ifdef BIST_INVERT_PASS_EN
    logic                    rd_inv_q, rd_inv_d;
    assign rd_inv = rd_inv_q;
`else
    assign rd_inv = 1'b0;
`endif

    logic                    busy_d, done_d, pass_d, we_d;
    logic [CW-1:0]           err_d;
    logic [addr_width-1:0]   fail_addr_d, addr_d;
    logic [data_width-1:0]   fail_data_d, wdata_d;

    // Next-state, compare and next-output decode; outputs are registered below.
    always_comb begin
        state_d     = state;
        a_d         = a;
        seed_d      = seed_q;
        rd_pend_d   = 1'b0;
        rd_addr_d   = rd_addr;
`ifdef BIST_INVERT_PASS_EN
        rd_inv_d    = 1'b0;
`endif
        err_d       = err_count;
        pass_d      = pass;
        fail_addr_d = fail_addr;
        fail_data_d = fail_data;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        we_d        = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;

        // Read data issued last cycle arrives now.
        if (rd_pend && (ram_rdata != pat(seed_q, rd_addr, rd_inv))) begin
            if (err_count == '0) begin
                fail_addr_d = rd_addr;
                fail_data_d = ram_rdata;
            end
            err_d = err_count + CW'(1);
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    a_d         = '0;
                    seed_d      = seed;
                    err_d       = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_WRITE: begin
                a_d = a + addr_width'(1);
                if (a == LAST_ADDR) begin
                    a_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_pend_d = 1'b1;
                rd_addr_d = a;
                a_d       = a + addr_width'(1);
                if (a == LAST_ADDR) begin
                    a_d     = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef BIST_INVERT_PASS_EN
                state_d = S_WRITE_INV;
`else
                state_d = S_DONE;
                pass_d  = (err_d == '0);
`endif
            end
`ifdef BIST_INVERT_PASS_EN
            S_WRITE_INV: begin
                a_d = a + addr_width'(1);
                if (a == LAST_ADDR) begin
                    a_d     = '0;
                    state_d = S_READ_INV;
                end
            end
            S_READ_INV: begin
                rd_pend_d = 1'b1;
                rd_addr_d = a;
                rd_inv_d  = 1'b1;
                a_d       = a + addr_width'(1);
                if (a == LAST_ADDR) begin
                    a_d     = '0;
                    state_d = S_DRAIN_INV;
                end
            end
            S_DRAIN_INV: begin
                state_d = S_DONE;
                pass_d  = (err_d == '0);
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output values for the cycle the next state occupies.
        case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            S_WRITE: begin
                we_d    = 1'b1;
                addr_d  = a_d;
                wdata_d = pat(seed_d, a_d, 1'b0);
            end
            S_READ: addr_d = a_d;
`ifdef BIST_INVERT_PASS_EN
            S_WRITE_INV: begin
                we_d    = 1'b1;
                addr_d  = a_d;
                wdata_d = pat(seed_d, a_d, 1'b1);
            end
            S_READ_INV: addr_d = a_d;
`endif
            default: ;
        endcase
    end

    // State, pipe and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a         <= '0;
            seed_q    <= '0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
`ifdef BIST_INVERT_PASS_EN
            rd_inv_q  <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_d;
            a         <= a_d;
            seed_q    <= seed_d;
            rd_pend   <= rd_pend_d;
            rd_addr   <= rd_addr_d;
`ifdef BIST_INVERT_PASS_EN
            rd_inv_q  <= rd_inv_d;
`endif
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_addr <= fail_addr_d;
            fail_data <= fail_data_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a fault-injecting RAM model.
module tb_ram_bist_ctrl;

    localparam int N = 16;
`ifdef BIST_INVERT_PASS_EN
    localparam int EXP_DONE = 4 * N + 3;
`else
    localparam int EXP_DONE = 2 * N + 2;
`endif

    logic       clk, rst, start, busy, done, pass, ram_we;
    logic [7:0] seed, fail_data, ram_wdata, ram_rdata;
    logic [5:0] err_count;
    logic [3:0] fail_addr, ram_addr;

    ram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: stuck-at faults applied on read at one address or all.
    logic [7:0] mem [N];
    logic       f_all;
    logic [3:0] f_addr;
    logic [7:0] f_clr, f_set;

    function automatic logic [7:0] ram_fault(input logic [7:0] d, input logic [3:0] ad);
        if (f_all || ad == f_addr) return (d & ~f_clr) | f_set;
        return d;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_fault(mem[ram_addr], ram_addr);
    end

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [7:0] seed;
        logic       f_all;
        logic [3:0] f_addr;
        logic [7:0] f_clr;
        logic [7:0] f_set;
        logic       exp_pass;
        logic [5:0] exp_err;
        logic [3:0] exp_fa;
        logic [7:0] exp_fd;
    } vec_t;
    vec_t vecs[5];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic set_fault(input logic all, input logic [3:0] ad,
                             input logic [7:0] clr, input logic [7:0] set);
        f_all = all; f_addr = ad; f_clr = clr; f_set = set;
    endtask

    // Runs one test from IDLE; returns in the cycle after done (IDLE again).
    task automatic run_bist(input logic [7:0] s, input bit hold, input logic exp_pass,
                            input logic [5:0] exp_err, input logic [3:0] exp_fa,
                            input logic [7:0] exp_fd);
        int  cyc, done_cyc, wd_bad;
        wr_t e;
        seed  = s;
        start = 1'b1;
        for (int i = 0; i < N; i++) wq.push_back({4'(i), s ^ 8'(i)});
`ifdef BIST_INVERT_PASS_EN
        for (int i = 0; i < N; i++) wq.push_back({4'(i), ~(s ^ 8'(i))});
`endif
        @(posedge clk); #1;
        start = hold;
        cyc = 1; done_cyc = 0; wd_bad = 0;
        chk("clr_err", 32'(err_count), 32'(0));
        chk("clr_pass", 32'(pass), 32'(0));
        chk("clr_fail_addr", 32'(fail_addr), 32'(0));
        chk("clr_fail_data", 32'(fail_data), 32'(0));
        chk("busy_cycle1", 32'(busy), 32'(1));
        while (done_cyc == 0 && cyc <= 200) begin
            if (ram_we) begin
                chk("wr_queue_nonempty", 32'(wq.size() != 0), 32'(1));
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(e.addr));
                    chk("wr_data", 32'(ram_wdata), 32'(e.data));
                end
            end else if (ram_wdata != 8'h00) begin
                wd_bad++;
            end
            if (done) begin
                done_cyc = cyc;
                chk("done_busy", 32'(busy), 32'(0));
                chk("pass", 32'(pass), 32'(exp_pass));
                chk("err_count", 32'(err_count), 32'(exp_err));
                chk("fail_addr", 32'(fail_addr), 32'(exp_fa));
                chk("fail_data", 32'(fail_data), 32'(exp_fd));
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", 32'(done_cyc != 0), 32'(1));
        chk("done_cycle", 32'(done_cyc), 32'(EXP_DONE));
        chk("wq_drained", 32'(wq.size()), 32'(0));
        chk("wdata_zero_when_idle_we", 32'(wd_bad), 32'(0));
        wq.delete();
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("pass_held", 32'(pass), 32'(exp_pass));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(ram_we), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_outs"}, 32'({done, pass, err_count, fail_addr, fail_data,
                                 ram_addr, ram_wdata}), 32'(0));
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; seed = 8'h00;
        set_fault(1'b0, 4'd0, 8'h00, 8'h00);

        vecs[0] = '{8'hA5, 1'b0, 4'd2, 8'h01, 8'h00, 1'b0, 6'd1,  4'd2, 8'hA6};
        vecs[1] = '{8'hA5, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 6'd0,  4'd0, 8'h00};
        vecs[2] = '{8'h3C, 1'b0, 4'd5, 8'h01, 8'h00, 1'b0, 6'd1,  4'd5, 8'h38};
        vecs[3] = '{8'h80, 1'b1, 4'd0, 8'h80, 8'h00, 1'b0, 6'd16, 4'd0, 8'h00};
`ifdef BIST_INVERT_PASS_EN
        vecs[4] = '{8'hA5, 1'b0, 4'd2, 8'h00, 8'h01, 1'b0, 6'd1,  4'd2, 8'h59};
`else
        vecs[4] = '{8'hA5, 1'b0, 4'd2, 8'h00, 8'h01, 1'b1, 6'd0,  4'd0, 8'h00};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // start held high: one run, next run only after returning to IDLE.
        run_bist(8'hA5, 1'b1, 1'b1, 6'd0, 4'd0, 8'h00);
        @(posedge clk); #1;
        chk("hold_restart_busy", 32'(busy), 32'(1));
        chk("hold_restart_we", 32'(ram_we), 32'(1));
        chk("hold_restart_addr", 32'(ram_addr), 32'(0));
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset asserted in cycle 8 aborts the run.
        seed = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("c8_we", 32'(ram_we), 32'(1));
        chk("c8_addr", 32'(ram_addr), 32'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort");
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'(0));
        run_bist(8'h00, 1'b0, 1'b1, 6'd0, 4'd0, 8'h00);

        // Table: back-to-back runs, failing run first then clean.
        for (int v = 0; v < 5; v++) begin
            set_fault(vecs[v].f_all, vecs[v].f_addr, vecs[v].f_clr, vecs[v].f_set);
            run_bist(vecs[v].seed, 1'b0, vecs[v].exp_pass, vecs[v].exp_err,
                     vecs[v].exp_fa, vecs[v].exp_fd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
